// File: rtl/regs_writeback.sv
// Write-side sequencer for the 16x16 register file. Merges memory loads,
// FIFO-buffered ALU results and 32-bit SP adjusts onto the single write port,
// and keeps a shadow copy of SP ({r15,r14}) so adjusts need no read port.
module regs_writeback #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] SP_RESET = 32'h0000_0000
) (
  input  logic                      cpu_clk,
  input  logic                      rst_n,
  input  logic                      mem_valid,
  input  logic [3:0]                mem_dst,
  input  logic [15:0]               mem_val,
  output logic                      mem_ready,
  input  logic                      alu_valid,
  input  logic [3:0]                alu_dst,
  input  logic [15:0]               alu_val,
  output logic                      alu_ready,
  input  logic                      sp_valid,
  input  logic [15:0]               sp_delta,
  output logic                      sp_ready,
  output logic                      we,
  output logic [3:0]                src_w,
  output logic [15:0]               val,
  output logic [31:0]               sp_value,
  output logic [$clog2(DEPTH):0]    alu_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SP_HI} state_t;
  state_t state, state_nx;

  logic [3:0]    fifo_dst [DEPTH];
  logic [15:0]   fifo_val [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, fifo_empty, fifo_full;

  logic          sel_we, gp_write;
  logic [3:0]    sel_dst;
  logic [15:0]   sel_val;
  logic [31:0]   sp_new, sp_nx;

  assign fifo_empty = (alu_count == '0);
  assign fifo_full  = (alu_count == CW'(DEPTH));
  // Acceptance of ALU results depends only on FIFO space, never on FSM state.
  assign alu_ready  = ~fifo_full;
  assign push       = alu_valid & ~fifo_full;
  assign sp_new     = sp_value + {{16{sp_delta[15]}}, sp_delta};

  // Source arbitration, SP sequencing and shadow-SP next value.
  always_comb begin
    state_nx  = state;
    mem_ready = 1'b0;
    sp_ready  = 1'b0;
    pop       = 1'b0;
    sel_we    = 1'b0;
    gp_write  = 1'b0;
    sel_dst   = 4'd0;
    sel_val   = 16'd0;
    sp_nx     = sp_value;
    case (state)
      IDLE: begin
        mem_ready = 1'b1;
        if (mem_valid) begin
          sel_dst = mem_dst;
          sel_val = mem_val;
          sel_we  = (mem_dst != 4'd0);
          gp_write = sel_we;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          sel_dst = fifo_dst[rd_ptr];
          sel_val = fifo_val[rd_ptr];
          sel_we  = (sel_dst != 4'd0);
          gp_write = sel_we;
        end else begin
          sp_ready = 1'b1;
          if (sp_valid) begin
            sp_nx    = sp_new;
            sel_we   = 1'b1;
            sel_dst  = 4'd14;
            sel_val  = sp_new[15:0];
            state_nx = SP_HI;
          end
        end
      end
      SP_HI: begin
        // Shadow already holds the new SP; emit its upper half to r15.
        sel_we   = 1'b1;
        sel_dst  = 4'd15;
        sel_val  = sp_value[31:16];
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Ordinary writes to r14/r15 keep the shadow coherent with the file.
    if (gp_write && sel_dst == 4'd14) sp_nx[15:0]  = sel_val;
    if (gp_write && sel_dst == 4'd15) sp_nx[31:16] = sel_val;
  end

  // State, registered write port, shadow SP and FIFO bookkeeping.
  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      we        <= 1'b0;
      src_w     <= 4'd0;
      val       <= 16'd0;
      sp_value  <= SP_RESET;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      alu_count <= '0;
    end else begin
      state     <= state_nx;
      we        <= sel_we;
      src_w     <= sel_dst;
      val       <= sel_val;
      sp_value  <= sp_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      alu_count <= alu_count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are qualified by the pointers so need no reset.
  always_ff @(posedge cpu_clk) begin
    if (push) begin
      fifo_dst[wr_ptr] <= alu_dst;
      fifo_val[wr_ptr] <= alu_val;
    end
  end
endmodule

// File: tb/tb_regs_writeback.sv
// Directed bench for regs_writeback: arbitration order, SP split writes,
// FIFO fill/drain, r0 drop, shadow tracking and reset during SP_HI.
module tb_regs_writeback;
  logic        cpu_clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, alu_valid, sp_valid;
  logic [3:0]  mem_dst, alu_dst;
  logic [15:0] mem_val, alu_val, sp_delta;
  logic        mem_ready, alu_ready, sp_ready, we;
  logic [3:0]  src_w;
  logic [15:0] val;
  logic [31:0] sp_value;
  logic [2:0]  alu_count;

  int n_cmp = 0;
  int n_err = 0;

  regs_writeback #(.DEPTH(4), .SP_RESET(32'h0000_0000)) dut (
    .cpu_clk(cpu_clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_val(mem_val), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_val(alu_val), .alu_ready(alu_ready),
    .sp_valid(sp_valid), .sp_delta(sp_delta), .sp_ready(sp_ready),
    .we(we), .src_w(src_w), .val(val), .sp_value(sp_value), .alu_count(alu_count)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [3:0] d, input logic [15:0] v);
    chk({tag, ".we"}, 32'(we), 32'd1);
    chk({tag, ".src"}, 32'(src_w), 32'(d));
    chk({tag, ".val"}, 32'(val), 32'(v));
  endtask

  task automatic idle_in();
    mem_valid = 0; alu_valid = 0; sp_valid = 0;
    mem_dst = 0; mem_val = 0; alu_dst = 0; alu_val = 0; sp_delta = 0;
  endtask

  task automatic sp_adjust(input string tag, input logic [15:0] d,
                           input logic [31:0] exp_sp);
    sp_valid = 1; sp_delta = d; #1;
    chk({tag, ".sp_ready"}, 32'(sp_ready), 32'd1);
    tick(); sp_valid = 0; #1;
    chk_wr({tag, ".lo"}, 4'd14, exp_sp[15:0]);
    chk({tag, ".sp"}, sp_value, exp_sp);
    chk({tag, ".sp_ready_hi"}, 32'(sp_ready), 32'd0);
    chk({tag, ".mem_ready_hi"}, 32'(mem_ready), 32'd0);
    tick();
    chk_wr({tag, ".hi"}, 4'd15, exp_sp[31:16]);
    tick();
    chk({tag, ".we_after"}, 32'(we), 32'd0);
  endtask

  task automatic mem_wr(input logic [3:0] d, input logic [15:0] v);
    mem_valid = 1; mem_dst = d; mem_val = v;
    tick(); mem_valid = 0;
  endtask

  initial begin
    int p;
    idle_in();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    repeat (5) tick();
    chk("rst.we", 32'(we), 32'd0);
    chk("rst.sp", sp_value, 32'h0000_0000);
    chk("rst.cnt", 32'(alu_count), 32'd0);
    chk("rst.mem_ready", 32'(mem_ready), 32'd1);
    chk("rst.alu_ready", 32'(alu_ready), 32'd1);
    chk("rst.sp_ready", 32'(sp_ready), 32'd1);

    // mem and alu together: mem first, alu the next cycle
    mem_valid = 1; mem_dst = 3; mem_val = 16'h1234;
    alu_valid = 1; alu_dst = 5; alu_val = 16'hBEEF;
    tick(); idle_in();
    chk_wr("pri.c1", 4'd3, 16'h1234);
    chk("pri.cnt", 32'(alu_count), 32'd1);
    tick();
    chk_wr("pri.c2", 4'd5, 16'hBEEF);
    tick();
    chk("pri.idle", 32'(we), 32'd0);
    chk("pri.cnt0", 32'(alu_count), 32'd0);

    // SP 0x0001_0000 + (-1)
    mem_wr(4'd15, 16'h0001);
    chk("sp.set", sp_value, 32'h0001_0000);
    tick();
    sp_adjust("sp.m1", 16'hFFFF, 32'h0000_FFFF);
    sp_adjust("sp.p1", 16'h0001, 32'h0001_0000);
    // wrap 0xFFFF_FFFF + 1 -> 0 and 0 + (-1) -> 0xFFFF_FFFF
    mem_wr(4'd14, 16'hFFFF);
    mem_wr(4'd15, 16'hFFFF);
    chk("sp.allones", sp_value, 32'hFFFF_FFFF);
    tick();
    sp_adjust("sp.wrap0", 16'h0001, 32'h0000_0000);
    sp_adjust("sp.wrapF", 16'hFFFF, 32'hFFFF_FFFF);

    // Fill FIFO while mem holds the port, then drain in order
    p = 0;
    mem_valid = 1; mem_dst = 1; mem_val = 16'h0101;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_dst = 4'(6 + p); alu_val = 16'(16'hA000 + p); #1;
      chk("fill.alu_ready", 32'(alu_ready), 32'(p < 4));
      chk("fill.sp_ready", 32'(sp_ready), 32'd0);
      tick();
      chk_wr("fill.mem", 4'd1, 16'h0101);
      if (p < 4) p++;
    end
    idle_in(); #1;
    chk("fill.cnt", 32'(alu_count), 32'd4);
    chk("fill.full", 32'(alu_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_wr("drain", 4'(6 + i), 16'(16'hA000 + i));
    end
    tick();
    chk("drain.idle", 32'(we), 32'd0);
    chk("drain.cnt", 32'(alu_count), 32'd0);

    // r0 is dropped
    alu_valid = 1; alu_dst = 0; alu_val = 16'h5555;
    tick(); idle_in();
    chk("r0.c1", 32'(we), 32'd0);
    tick();
    chk("r0.c2", 32'(we), 32'd0);
    chk("r0.cnt", 32'(alu_count), 32'd0);

    // ALU write to r15 updates shadow high half
    alu_valid = 1; alu_dst = 15; alu_val = 16'hABCD;
    tick(); idle_in();
    tick();
    chk_wr("r15", 4'd15, 16'hABCD);
    chk("r15.sp", sp_value, 32'hABCD_FFFF);
    tick();
    chk("r15.sp_hold", sp_value, 32'hABCD_FFFF);

    // Reset while in SP_HI drops the high write
    sp_valid = 1; sp_delta = 16'h0010;
    tick(); sp_valid = 0;
    chk_wr("rsthi.lo", 4'd14, 16'h000F);
    chk("rsthi.sp", sp_value, 32'hABCE_000F);
    alu_valid = 1; alu_dst = 7; alu_val = 16'h7777; #1;
    chk("rsthi.alu_ready", 32'(alu_ready), 32'd1);
    rst_n = 0;
    tick(); idle_in();
    rst_n = 1;
    chk("rsthi.we", 32'(we), 32'd0);
    chk("rsthi.sp_rst", sp_value, 32'h0000_0000);
    chk("rsthi.cnt", 32'(alu_count), 32'd0);
    tick();
    chk("rsthi.no_hi", 32'(we), 32'd0);
    chk("rsthi.sp_ready", 32'(sp_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
